// File: rtl/pwm_fader.sv
// Purpose : sequences per-channel PWM duty values, ramping each toward a host-written target.
// Latency : writes land on the accepting edge; ramps move one LSB per channel per step period.
// Backpres: wr_ready drops for the CHANNELS-cycle scan; a held wr_valid is taken on the first idle cycle.
//
// Ports
//   clk, rst_n             single clock, asynchronous active-low reset
//   wr_valid/wr_ready      host write handshake (wr_chan, wr_target, wr_snap qualify it)
//   duty                   packed registered duty, channel i at [i*LENGTH +: LENGTH]
//   at_target              per-channel duty == target
//   busy                   high while the scan walks the channels
module pwm_fader #(
    parameter int LENGTH   = 8,
    parameter int CHANNELS = 4,
    parameter int STEP_DIV = 1024
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         wr_valid,
    output logic                         wr_ready,
    input  logic [$clog2(CHANNELS)-1:0]  wr_chan,
    input  logic [LENGTH-1:0]            wr_target,
    input  logic                         wr_snap,
    output logic [CHANNELS*LENGTH-1:0]   duty,
    output logic [CHANNELS-1:0]          at_target,
    output logic                         busy
);

    localparam int IDX_W = $clog2(CHANNELS);
    // STEP_DIV >= CHANNELS+2 >= 4, so the prescaler is always at least 2 bits wide.
    localparam int PRE_W = $clog2(STEP_DIV);

    localparam logic [PRE_W-1:0] PRE_MAX  = PRE_W'(STEP_DIV - 1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHANNELS - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [PRE_W-1:0]  presc_q,    presc_d;
    state_t            state_q,    state_d;
    logic [IDX_W-1:0]  scan_idx_q, scan_idx_d;
    logic [LENGTH-1:0] target_q [CHANNELS];
    logic [LENGTH-1:0] target_d [CHANNELS];
    logic [LENGTH-1:0] duty_q   [CHANNELS];
    logic [LENGTH-1:0] duty_d   [CHANNELS];

    logic step_tick;
    logic wr_fire;
    logic scan_upd;

    // ------------------------------------------------------------------
    // Prescaler: free-running, independent of the FSM, so the step period
    // never stretches when writes or scans are in progress.
    // ------------------------------------------------------------------
    always_comb begin
        step_tick = (presc_q == PRE_MAX);
        presc_d   = step_tick ? '0 : presc_q + PRE_W'(1);
    end

    // Writes are only taken while idle, so a write and a scan update can
    // never touch the same registers on the same edge.
    assign wr_fire  = wr_valid && (state_q == ST_IDLE);
    assign scan_upd = (state_q == ST_SCAN);

    // ------------------------------------------------------------------
    // Scan sequencer
    // ------------------------------------------------------------------
    always_comb begin
        state_d    = state_q;
        scan_idx_d = scan_idx_q;
        case (state_q)
            ST_IDLE: begin
                if (step_tick) begin
                    state_d    = ST_SCAN;
                    scan_idx_d = '0;
                end
            end
            ST_SCAN: begin
                if (scan_idx_q == LAST_IDX) begin
                    state_d    = ST_IDLE;
                    scan_idx_d = '0;
                end else begin
                    scan_idx_d = scan_idx_q + IDX_W'(1);
                end
            end
            default: begin
                state_d    = ST_IDLE;
                scan_idx_d = '0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Per-channel target / duty next-state.
    // A write that coincides with the tick lands before the scan starts,
    // so the scan naturally sees the new target (and snapped duty).
    // The saturating compare means the ramp can never wrap.
    // ------------------------------------------------------------------
    always_comb begin
        for (int i = 0; i < CHANNELS; i++) begin
            target_d[i] = target_q[i];
            duty_d[i]   = duty_q[i];
            if (wr_fire && (wr_chan == IDX_W'(i))) begin
                target_d[i] = wr_target;
                if (wr_snap) begin
                    duty_d[i] = wr_target;
                end
            end else if (scan_upd && (scan_idx_q == IDX_W'(i))) begin
                if (duty_q[i] < target_q[i]) begin
                    duty_d[i] = duty_q[i] + LENGTH'(1);
                end else if (duty_q[i] > target_q[i]) begin
                    duty_d[i] = duty_q[i] - LENGTH'(1);
                end
            end
        end
    end

    // ------------------------------------------------------------------
    // All state in one register block; reset clears everything at once,
    // including an in-flight scan.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_q    <= '0;
            state_q    <= ST_IDLE;
            scan_idx_q <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                target_q[i] <= '0;
                duty_q[i]   <= '0;
            end
        end else begin
            presc_q    <= presc_d;
            state_q    <= state_d;
            scan_idx_q <= scan_idx_d;
            for (int i = 0; i < CHANNELS; i++) begin
                target_q[i] <= target_d[i];
                duty_q[i]   <= duty_d[i];
            end
        end
    end

    // ------------------------------------------------------------------
    // Outputs: duty straight from flops; at_target is a plain compare.
    // ------------------------------------------------------------------
    for (genvar g = 0; g < CHANNELS; g++) begin : g_out
        assign duty[g*LENGTH +: LENGTH] = duty_q[g];
        assign at_target[g]             = (duty_q[g] == target_q[g]);
    end

    assign wr_ready = (state_q == ST_IDLE);
    assign busy     = (state_q == ST_SCAN);

endmodule

// File: tb/tb_pwm_fader.sv
// Purpose : self-checking bench for pwm_fader (LENGTH=8, CHANNELS=4, STEP_DIV=16).
// Latency : expectations are queued by stimulus and popped by a monitor on write accept / scan end.
// Backpres: writes are held until wr_ready; every wait is cycle-bounded.
module tb_pwm_fader;

    localparam int LENGTH   = 8;
    localparam int CHANNELS = 4;
    localparam int STEP_DIV = 16;

    logic        clk;
    logic        rst_n;
    logic        wr_valid;
    logic        wr_ready;
    logic [1:0]  wr_chan;
    logic [7:0]  wr_target;
    logic        wr_snap;
    logic [31:0] duty;
    logic [3:0]  at_target;
    logic        busy;

    typedef struct {
        logic [31:0] duty;
        logic [3:0]  at;
    } exp_t;

    exp_t wr_q[$];
    exp_t scan_q[$];

    int n_checks = 0;
    int n_err    = 0;
    int scan_cnt = 0;

    pwm_fader #(
        .LENGTH   (LENGTH),
        .CHANNELS (CHANNELS),
        .STEP_DIV (STEP_DIV)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .wr_valid  (wr_valid),
        .wr_ready  (wr_ready),
        .wr_chan   (wr_chan),
        .wr_target (wr_target),
        .wr_snap   (wr_snap),
        .duty      (duty),
        .at_target (at_target),
        .busy      (busy)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: samples just after each rising edge.
    initial begin
        logic acc;
        logic busy_prev;
        exp_t e;
        busy_prev = 1'b0;
        forever begin
            @(posedge clk);
            acc = rst_n && wr_valid && wr_ready;
            #1;
            if (acc) begin
                if (wr_q.size() == 0) begin
                    n_checks++;
                    n_err++;
                    $display("FAIL wr_unexpected: accept seen with no expectation queued");
                end else begin
                    e = wr_q.pop_front();
                    chk("wr_duty", duty, e.duty);
                    chk("wr_at_target", 32'(at_target), 32'(e.at));
                end
            end
            if (!rst_n) begin
                busy_prev = 1'b0;
            end else begin
                if (busy_prev && !busy) begin
                    scan_cnt++;
                    if (scan_q.size() != 0) begin
                        e = scan_q.pop_front();
                        chk("scan_duty", duty, e.duty);
                        chk("scan_at_target", 32'(at_target), 32'(e.at));
                    end
                end
                busy_prev = busy;
            end
        end
    end

    task automatic push_scan(input logic [31:0] d, input logic [3:0] a);
        exp_t e;
        e.duty = d;
        e.at   = a;
        scan_q.push_back(e);
    endtask

    // Returns on the first falling edge after a scan has completed.
    task automatic wait_scan();
        int  start;
        bit  seen;
        start = scan_cnt;
        seen  = 1'b0;
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            if (scan_cnt != start) seen = 1'b1;
        end
        if (!seen) begin
            n_checks++;
            n_err++;
            $display("FAIL scan_timeout: no scan end within 40 cycles");
        end
    endtask

    // Call on a falling edge. Holds the write until accepted; returns on the
    // falling edge after the accepting edge. waits = idle-blocked cycles seen.
    task automatic do_write(input logic [1:0] ch, input logic [7:0] tgt, input logic snap,
                            input logic [31:0] exp_duty, input logic [3:0] exp_at,
                            output int waits);
        exp_t e;
        e.duty = exp_duty;
        e.at   = exp_at;
        wr_q.push_back(e);
        wr_chan   = ch;
        wr_target = tgt;
        wr_snap   = snap;
        wr_valid  = 1'b1;
        waits     = 0;
        while (!wr_ready && waits < 40) begin
            waits++;
            @(negedge clk);
        end
        if (!wr_ready) begin
            n_checks++;
            n_err++;
            $display("FAIL wr_timeout: write to ch%0d never accepted", ch);
            void'(wr_q.pop_back());
            wr_valid = 1'b0;
        end else begin
            @(posedge clk);
            @(negedge clk);
            wr_valid = 1'b0;
        end
    endtask

    initial begin
        int w;
        int cnt;
        rst_n     = 1'b0;
        wr_valid  = 1'b0;
        wr_chan   = '0;
        wr_target = '0;
        wr_snap   = 1'b0;

        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        // Give the block some state, then pulse reset mid-cycle.
        do_write(2'd0, 8'hAA, 1'b1, 32'h0000_00AA, 4'hF, w);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rst_duty",      duty,            32'h0);
        chk("rst_at_target", 32'(at_target),  32'hF);
        chk("rst_wr_ready",  32'(wr_ready),   32'h1);
        chk("rst_busy",      32'(busy),       32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // Ramp-up: ch1 -> 3, one LSB per scan.
        do_write(2'd1, 8'h03, 1'b0, 32'h0000_0000, 4'hD, w);
        push_scan(32'h0000_0100, 4'hD);
        push_scan(32'h0000_0200, 4'hD);
        push_scan(32'h0000_0300, 4'hF);
        repeat (3) wait_scan();

        // Snap: ch2 -> FF immediately, next scan leaves it alone.
        do_write(2'd2, 8'hFF, 1'b1, 32'h00FF_0300, 4'hF, w);
        push_scan(32'h00FF_0300, 4'hF);
        wait_scan();

        // Redirect: ch0 snapped to 10, ramp down toward 00, then retarget to 20.
        do_write(2'd0, 8'h10, 1'b1, 32'h00FF_0310, 4'hF, w);
        do_write(2'd0, 8'h00, 1'b0, 32'h00FF_0310, 4'hE, w);
        push_scan(32'h00FF_030F, 4'hE);
        push_scan(32'h00FF_030E, 4'hE);
        repeat (2) wait_scan();
        do_write(2'd0, 8'h20, 1'b0, 32'h00FF_030E, 4'hE, w);
        for (int k = 1; k <= 18; k++) begin
            push_scan(32'h00FF_030E + 32'(k), (k == 18) ? 4'hF : 4'hE);
        end
        push_scan(32'h00FF_0320, 4'hF);
        repeat (19) wait_scan();

        // Handshake: 11 falling edges on, the prescaler sits on its tick value.
        repeat (11) @(negedge clk);
        push_scan(32'h01FF_0320, 4'h7);
        do_write(2'd3, 8'h02, 1'b0, 32'h00FF_0320, 4'h7, w);
        chk("hs_tick_accept_waits", 32'(w), 32'd0);
        do_write(2'd1, 8'h07, 1'b1, 32'h01FF_0720, 4'h7, w);
        chk("hs_held_waits", 32'(w), 32'd4);
        push_scan(32'h02FF_0720, 4'hF);
        wait_scan();

        // Mid-ramp reset: ch3 heading for 80, reset dropped inside a scan.
        do_write(2'd3, 8'h80, 1'b0, 32'h02FF_0720, 4'h7, w);
        push_scan(32'h03FF_0720, 4'h7);
        wait_scan();
        repeat (13) @(negedge clk);
        chk("mid_busy_before_rst", 32'(busy), 32'h1);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_duty",      duty,           32'h0);
        chk("mid_rst_at_target", 32'(at_target), 32'hF);
        chk("mid_rst_wr_ready",  32'(wr_ready),  32'h1);
        chk("mid_rst_busy",      32'(busy),      32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        cnt = 0;
        while (!busy && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("first_tick_after_release", 32'(cnt), 32'd16);
        chk("post_rst_duty", duty, 32'h0);
        push_scan(32'h0000_0000, 4'hF);
        wait_scan();

        chk("wr_q_drained",   32'(wr_q.size()),   32'd0);
        chk("scan_q_drained", 32'(scan_q.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/pwm_fader.md
PWM_FADER -- requirements
Module: pwm_fader

Interface
REQ-001 The block SHALL have parameter LENGTH, default 8, meaning the duty width per channel, matching the pwm block's LENGTH.
REQ-002 The block SHALL have parameter CHANNELS, default 4, meaning the number of pwm channels sequenced (range 2..16).
REQ-003 The block SHALL have parameter STEP_DIV, default 1024, meaning the clk cycles between ramp steps; legal range is STEP_DIV >= CHANNELS+2.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port wr_valid, input, 1 bit: the host presents a channel target.
REQ-007 The block SHALL have port wr_ready, output, 1 bit: the block can accept a write this cycle.
REQ-008 The block SHALL have port wr_chan, input, clog2(CHANNELS) bits: the channel index of the write.
REQ-009 The block SHALL have port wr_target, input, LENGTH bits: the target duty for that channel.
REQ-010 The block SHALL have port wr_snap, input, 1 bit: 1 means jump the duty to the target immediately; 0 means ramp to it.
REQ-011 The block SHALL have port duty, output, CHANNELS*LENGTH bits: channel i duty is bits [i*LENGTH +: LENGTH], driving pwm duty inputs.
REQ-012 The block SHALL have port at_target, output, CHANNELS bits: bit i is 1 when duty i equals target i.
REQ-013 The block SHALL have port busy, output, 1 bit: 1 while in state SCAN.

Function
REQ-014 Per channel, the block SHALL hold a target register and a duty register, each LENGTH bits; duty registers SHALL drive the duty output directly (no combinational path from inputs).
REQ-015 The prescaler SHALL count 0..STEP_DIV-1, wrap to 0, and assert an internal step tick in the cycle where it equals STEP_DIV-1; it SHALL run regardless of FSM state.
REQ-016 The FSM SHALL have two states: IDLE and SCAN.
REQ-017 From IDLE, a step tick SHALL transition the FSM to SCAN with the scan index at 0.
REQ-018 In SCAN, each cycle SHALL update channel scan_idx and increment scan_idx; after channel CHANNELS-1 is updated, the FSM SHALL return to IDLE, so SCAN lasts exactly CHANNELS cycles.
REQ-019 Each SCAN update SHALL set duty to duty+1 if duty<target, to duty-1 if duty>target, and leave it unchanged if duty equals target; the step is unsigned and never wraps past 0 or 2^LENGTH-1.
REQ-020 wr_ready SHALL equal 1 exactly when the FSM is in IDLE; busy SHALL equal NOT wr_ready.
REQ-021 A write is accepted on a rising edge where wr_valid and wr_ready are both 1; on that edge target[wr_chan] SHALL load wr_target.
REQ-022 On an accepted write with wr_snap=1, duty[wr_chan] SHALL load wr_target on the same edge.
REQ-023 On an accepted write with wr_snap=0, duty SHALL be untouched by the write and SHALL move only in subsequent SCAN updates.
REQ-024 If a write is accepted on the same edge that the tick moves the FSM to SCAN, the write SHALL take effect first, and the scan SHALL use the new target (and the snapped duty, if wr_snap=1).
REQ-025 A write accepted while the channel is mid-ramp SHALL redirect it; from its current duty, the ramp continues toward the new target.
REQ-026 at_target SHALL be a combinational compare of the registered duty and target values per channel.
REQ-027 A held wr_valid during SCAN SHALL be accepted in the first IDLE cycle; the host keeps wr_chan, wr_target and wr_snap stable until accepted.

Reset
REQ-028 While rst_n=0, the block SHALL hold all duty=0, all targets=0, prescaler=0, FSM=IDLE and scan_idx=0, giving wr_ready=1, busy=0 and at_target all ones.
REQ-029 Reset assertion SHALL take effect immediately, independent of clk, including mid-SCAN or mid-ramp; release SHALL be synchronous-deasserted externally, and counting SHALL restart from 0.

Verification (LENGTH=8, CHANNELS=4, STEP_DIV=16)
REQ-030 Reset test: pulse rst_n low mid-cycle -> duty=0 on every channel, at_target=4'b1111, wr_ready=1 and busy=0, all without waiting for a clk edge.
REQ-031 Ramp-up test: write ch1 target 8'h03 with snap=0 -> duty1 steps 1,2,3 on three consecutive scans (16 cycles apart); at_target[1]=0 until duty1=3; other channels stay 0.
REQ-032 Snap test: write ch2 target 8'hFF with snap=1 -> duty2=8'hFF the cycle after acceptance and at_target[2]=1; the next scan leaves duty2 unchanged.
REQ-033 Redirect test: snap ch0 to 8'h10, then write target 8'h00 with snap=0; after two scans (duty0=8'h0E), write target 8'h20 -> duty0 goes 8'h0F, 8'h10, ... up to 8'h20, then holds.
REQ-034 Handshake test: hold wr_valid from the cycle of a step tick -> the write is accepted on the tick edge (REQ-024); a second write held during SCAN sees wr_ready=0 for exactly 4 cycles and is accepted in the first IDLE cycle.
REQ-035 Mid-ramp reset test: ramp ch3 toward 8'h80, then drop rst_n during SCAN -> all duty and targets are 0 and FSM=IDLE immediately; after release, the first tick occurs 16 cycles later.
